ifetch_sa_cache: RTL and testbench
==================================

// Module: ifetch_sa_cache
// PURPOSE
//  Instruction fetch unit with set-associative I-cache and bimodal branch predictor; next generation of the fetch stage.
//  Sits between MemCtrl (block refills) and the instruction decoder; takes redirects and branch outcomes from the ROB.
//  Issues at most one instruction per cycle with a predicted next PC (JAL taken, Bcc via 2-bit BHT, all others PC+4).
// PARAMETERS
//  BLK_WORDS    16   32-bit words per cache block, power of 2, >=2; mc_data width = 32*BLK_WORDS
//  SETS         16   cache sets, power of 2
//  WAYS         2    associativity, 1 or 2 only
//  BHT_ENTRIES  256  2-bit counters, power of 2, indexed by pc[log2(BHT_ENTRIES)+1:2]
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous active-high reset
//  rdy            in   1              global enable; 0 freezes all state
//  inst           out  32             fetched instruction
//  inst_rdy       out  1              inst/inst_pc/inst_pred_jump valid this cycle
//  inst_pc        out  32             PC of inst
//  inst_pred_jump out  1              1 = predicted taken
//  mc_en          out  1              block refill request, held high until mc_done
//  mc_addr        out  32             block-aligned refill address
//  mc_data        in   32*BLK_WORDS   refill block, word 0 in bits [31:0]
//  mc_done        in   1              refill complete, mc_data valid (one-cycle pulse)
//  rob_set_pc_en  in   1              redirect (mispredict / exception)
//  rob_set_pc     in   32             redirect target
//  rs_nxt_full    in   1              RS full next cycle
//  lsb_nxt_full   in   1              LSB full next cycle
//  rob_nxt_full   in   1              ROB full next cycle
//  rob_br         in   1              committed conditional branch
//  rob_br_jump    in   1              its actual direction (1 = taken)
//  rob_br_pc      in   32             its PC
// BEHAVIOUR
//  Reset: pc=0, inst=0, inst_pc=0, inst_rdy=0, inst_pred_jump=0, mc_en=0, mc_addr=0, all valid=0, LRU=0, BHT=2'b01.
//  Address split: offset=[log2(BLK_WORDS)+1:2], index=next log2(SETS) bits, tag=remaining upper bits.
//  Lookup is combinational on pc; hit = any way valid with matching tag.
//  Issue: hit && !rs/lsb/rob_nxt_full && !rob_set_pc_en -> next cycle inst_rdy=1, inst, inst_pc=pc,
//   inst_pred_jump, pc<=pred_pc; otherwise inst_rdy=0 and pc holds. One-cycle hit-to-output latency.
//  Prediction: JAL -> pc+J-imm, taken; Bcc with counter>=2 -> pc+B-imm, taken; else pc+4, not taken. Sums mod 2^32.
//  Redirect: pc<=rob_set_pc, inst_rdy=0 that cycle; takes priority over issue.
//  FSM IDLE: miss -> mc_en=1, mc_addr={pc tag,index,0s}, go WAIT_MEM.
//  FSM WAIT_MEM: mc_en, mc_addr stable; on mc_done install block into victim way, set valid+tag, mc_en=0, go IDLE.
//   Fill not bypassed: the filled block hits from the cycle after install.
//  Victim: WAYS=1 -> way 0; WAYS=2 -> first invalid way (way 0 first), else LRU way.
//  LRU (WAYS=2, one bit per set): updated to the other way on each issue hit and each install.
//  Redirect during WAIT_MEM: the refill is not aborted; the block is installed; the new pc misses/hits afterwards.
//  Redirect and mc_done in the same cycle: both take effect.
//  BHT: on rob_br, counter saturating +1 (taken) / -1 (not taken), bounds 0..3.
//   Update in the same cycle as a read of the same entry: prediction uses the pre-update value.
//  rdy=0: no state change, mc_en/mc_addr held, inst_rdy holds its previous value.
// CONFIGURATION
//  IFETCH_PREFETCH_EN defined: next-line prefetch.
//   After a demand install of block B, if B+1 (mc_addr + 4*BLK_WORDS, wrap mod 2^32) misses, go PREFETCH.
//   PREFETCH issues B+1 exactly like WAIT_MEM and installs it; demand misses wait until it completes.
//   A redirect does not cancel a prefetch.
//  IFETCH_PREFETCH_EN undefined: no PREFETCH state; only demand misses request memory.
// TESTING
//  Cold start pc=0 -> mc_en=1, mc_addr=0; mc_done with word0=0x00000013 -> 1 cycle later inst_rdy=1, inst=0x13, inst_pc=0.
//  JAL at 0x8 (0x0100006F, +16) -> inst_pred_jump=1; next inst_pc=0x18.
//  BHT: Bcc at 0x40 committed taken twice (counter 1->3) -> next fetch of 0x40 inst_pred_jump=1 to target.
//   Then 2 not-taken commits -> counter 1, pred not taken, next inst_pc=0x44.
//  WAYS=2: fill 0x0000, then 0x0000+SETS*BLK_WORDS*4 (same set); touch first; fill a third alias -> second evicted,
//   first still hits.
//  rob_set_pc_en=1 (0x200) during WAIT_MEM for 0x0 -> fill of 0x0 installed, then mc_addr=0x200;
//   no inst_rdy for stale PCs.
//  rob_nxt_full=1 on a hit -> inst_rdy=0, pc held; deassert -> issue resumes at the same PC.
//   With IFETCH_PREFETCH_EN: the miss at 0x0 is followed by a request at 4*BLK_WORDS.

Source files
------------

// File: rtl/ifetch_sa_cache.sv
// rtl/ifetch_sa_cache.sv - fetch unit: set-associative I-cache, bimodal BHT, one instruction per cycle
// Optional next-line prefetch when IFETCH_PREFETCH_EN is defined.
module ifetch_sa_cache #(
   parameter int BLK_WORDS   = 16,
   parameter int SETS        = 16,
   parameter int WAYS        = 2,
   parameter int BHT_ENTRIES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   output logic [31:0]             inst,
   output logic                    inst_rdy,
   output logic [31:0]             inst_pc,
   output logic                    inst_pred_jump,
   output logic                    mc_en,
   output logic [31:0]             mc_addr,
   input  logic [32*BLK_WORDS-1:0] mc_data,
   input  logic                    mc_done,
   input  logic                    rob_set_pc_en,
   input  logic [31:0]             rob_set_pc,
   input  logic                    rs_nxt_full,
   input  logic                    lsb_nxt_full,
   input  logic                    rob_nxt_full,
   input  logic                    rob_br,
   input  logic                    rob_br_jump,
   input  logic [31:0]             rob_br_pc
);
   localparam int OFF_W    = $clog2(BLK_WORDS);
   localparam int IDX_W    = $clog2(SETS);
   localparam int TAG_W    = 30 - OFF_W - IDX_W;
   localparam int BHT_W    = $clog2(BHT_ENTRIES);
   localparam int BLK_BITS = 32 * BLK_WORDS;

`ifdef IFETCH_PREFETCH_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_PREFETCH} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM} state_t;
`endif

   logic [BLK_BITS-1:0] data_q [WAYS][SETS];
   logic [TAG_W-1:0]    tag_q  [WAYS][SETS];
   logic [WAYS-1:0]     valid_q [SETS];
   logic [SETS-1:0]     lru_q;
   logic [1:0]          bht_q [BHT_ENTRIES];

   state_t      state_q, state_d;
   logic [31:0] pc_q, inst_q, inst_pc_q, mc_addr_q, mc_addr_d;
   logic        inst_rdy_q, pred_q, mc_en_q, mc_en_d;

   logic [IDX_W-1:0]    pc_idx, mc_idx;
   logic [TAG_W-1:0]    pc_tag, mc_tag;
   logic [OFF_W-1:0]    pc_off;
   logic                hit, hit_way, victim, issue, install, pred_jump;
   logic [BLK_BITS-1:0] hit_blk;
   logic [31:0]         word, pred_pc, j_imm, b_imm;
   logic [BHT_W-1:0]    br_idx;
   logic                unused_br_pc_bits;

   assign pc_off = pc_q[2 +: OFF_W];
   assign pc_idx = pc_q[OFF_W+2 +: IDX_W];
   assign pc_tag = pc_q[31 -: TAG_W];
   assign mc_idx = mc_addr_q[OFF_W+2 +: IDX_W];
   assign mc_tag = mc_addr_q[31 -: TAG_W];
   assign br_idx = rob_br_pc[BHT_W+1:2];
   assign unused_br_pc_bits = ^{rob_br_pc[31:BHT_W+2], rob_br_pc[1:0]};

   always_comb begin
      hit     = 1'b0;
      hit_way = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[pc_idx][w] && tag_q[w][pc_idx] == pc_tag) begin
            hit     = 1'b1;
            hit_way = w[0];
         end
      end
   end

   assign hit_blk = data_q[hit_way][pc_idx];
   assign word    = hit_blk[{pc_off, 5'b0} +: 32];
   assign j_imm   = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
   assign b_imm   = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};

   // BHT is read before any same-cycle commit lands, so prediction sees the old counter
   always_comb begin
      pred_pc   = pc_q + 32'd4;
      pred_jump = 1'b0;
      if (word[6:0] == 7'b1101111) begin
         pred_pc   = pc_q + j_imm;
         pred_jump = 1'b1;
      end else if (word[6:0] == 7'b1100011 && bht_q[pc_q[BHT_W+1:2]][1]) begin
         pred_pc   = pc_q + b_imm;
         pred_jump = 1'b1;
      end
   end

   assign issue = hit && !rs_nxt_full && !lsb_nxt_full && !rob_nxt_full && !rob_set_pc_en;

   always_comb begin
      victim = 1'b0;
      if (WAYS == 2) begin
         if (!valid_q[mc_idx][0])      victim = 1'b0;
         else if (!valid_q[mc_idx][1]) victim = 1'b1;
         else                          victim = lru_q[mc_idx];
      end
   end

`ifdef IFETCH_PREFETCH_EN
   logic [IDX_W-1:0] nxt_idx;
   logic [TAG_W-1:0] nxt_tag;
   logic             nxt_hit;
   assign {nxt_tag, nxt_idx} = mc_addr_q[31:OFF_W+2] + 1'b1;
   always_comb begin
      nxt_hit = 1'b0;
      for (int w = 0; w < WAYS; w++)
         if (valid_q[nxt_idx][w] && tag_q[w][nxt_idx] == nxt_tag) nxt_hit = 1'b1;
   end
`endif

   // A miss seen while a redirect is pending would fetch a stale block, so it waits a cycle
   always_comb begin
      state_d   = state_q;
      mc_en_d   = mc_en_q;
      mc_addr_d = mc_addr_q;
      install   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!hit && !rob_set_pc_en) begin
               mc_en_d   = 1'b1;
               mc_addr_d = {pc_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
               state_d   = S_WAIT_MEM;
            end
         end
         S_WAIT_MEM: begin
            if (mc_done) begin
               install = 1'b1;
               mc_en_d = 1'b0;
               state_d = S_IDLE;
`ifdef IFETCH_PREFETCH_EN
               if (!nxt_hit) begin
                  mc_en_d   = 1'b1;
                  mc_addr_d = {nxt_tag, nxt_idx, {(OFF_W+2){1'b0}}};
                  state_d   = S_PREFETCH;
               end
`endif
            end
         end
`ifdef IFETCH_PREFETCH_EN
         S_PREFETCH: begin
            if (mc_done) begin
               install = 1'b1;
               mc_en_d = 1'b0;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mc_en_q    <= 1'b0;
         mc_addr_q  <= 32'd0;
         pc_q       <= 32'd0;
         inst_q     <= 32'd0;
         inst_pc_q  <= 32'd0;
         inst_rdy_q <= 1'b0;
         pred_q     <= 1'b0;
      end else if (rdy) begin
         state_q    <= state_d;
         mc_en_q    <= mc_en_d;
         mc_addr_q  <= mc_addr_d;
         inst_rdy_q <= issue;
         if (rob_set_pc_en) begin
            pc_q <= rob_set_pc;
         end else if (issue) begin
            pc_q      <= pred_pc;
            inst_q    <= word;
            inst_pc_q <= pc_q;
            pred_q    <= pred_jump;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
         lru_q <= '0;
         for (int b = 0; b < BHT_ENTRIES; b++) bht_q[b] <= 2'b01;
      end else if (rdy) begin
         if (issue && WAYS == 2) lru_q[pc_idx] <= ~hit_way;
         if (install) begin
            tag_q[victim][mc_idx]   <= mc_tag;
            valid_q[mc_idx][victim] <= 1'b1;
            if (WAYS == 2) lru_q[mc_idx] <= ~victim;
         end
         if (rob_br) begin
            if (rob_br_jump && bht_q[br_idx] != 2'b11)
               bht_q[br_idx] <= bht_q[br_idx] + 2'd1;
            else if (!rob_br_jump && bht_q[br_idx] != 2'b00)
               bht_q[br_idx] <= bht_q[br_idx] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy && install) data_q[victim][mc_idx] <= mc_data;
   end

   assign inst           = inst_q;
   assign inst_rdy       = inst_rdy_q;
   assign inst_pc        = inst_pc_q;
   assign inst_pred_jump = pred_q;
   assign mc_en          = mc_en_q;
   assign mc_addr        = mc_addr_q;
endmodule

// File: tb/tb_ifetch_sa_cache.sv
// tb/tb_ifetch_sa_cache.sv - scoreboard bench for ifetch_sa_cache with a latency-modelled block memory
module tb_ifetch_sa_cache;
   localparam int BLK_WORDS = 16;
   localparam int MEM_LAT   = 4;
   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] JAL  = 32'h0100006F;
   localparam logic [31:0] BEQ  = 32'h02000063;
   localparam logic [31:0] I400 = 32'h00100093;
   localparam logic [31:0] I800 = 32'h00200113;
   localparam logic [31:0] I200 = 32'h00300193;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        jump;
   } issue_t;

   logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
   logic [31:0] inst, inst_pc, mc_addr, rob_set_pc = '0, rob_br_pc = '0;
   logic inst_rdy, inst_pred_jump, mc_en;
   logic [32*BLK_WORDS-1:0] mc_data;
   logic mc_done;
   logic rob_set_pc_en = 1'b0, rs_nxt_full = 1'b0, lsb_nxt_full = 1'b0, rob_nxt_full = 1'b1;
   logic rob_br = 1'b0, rob_br_jump = 1'b0;

   issue_t      exp_q[$];
   logic [31:0] req_log[$];
   logic [31:0] prog [logic [31:0]];
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   ifetch_sa_cache #(.BLK_WORDS(BLK_WORDS), .SETS(16), .WAYS(2), .BHT_ENTRIES(256)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .inst(inst), .inst_rdy(inst_rdy), .inst_pc(inst_pc),
      .inst_pred_jump(inst_pred_jump), .mc_en(mc_en), .mc_addr(mc_addr), .mc_data(mc_data),
      .mc_done(mc_done), .rob_set_pc_en(rob_set_pc_en), .rob_set_pc(rob_set_pc),
      .rs_nxt_full(rs_nxt_full), .lsb_nxt_full(lsb_nxt_full), .rob_nxt_full(rob_nxt_full),
      .rob_br(rob_br), .rob_br_jump(rob_br_jump), .rob_br_pc(rob_br_pc));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return prog.exists(a) ? prog[a] : NOP;
   endfunction

   initial begin
      logic [31:0] a;
      mc_done = 1'b0;
      mc_data = '0;
      forever begin
         @(negedge clk);
         mc_done = 1'b0;
         if (mc_en && !rst && rdy) begin
            a = mc_addr;
            req_log.push_back(a);
            repeat (MEM_LAT) @(negedge clk);
            for (int i = 0; i < BLK_WORDS; i++) mc_data[i*32 +: 32] = mem_word(a + 32'(4*i));
            mc_done = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected test done");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic j);
      exp_q.push_back('{pc: pc, inst: ins, jump: j});
   endtask

   task automatic redirect(input logic [31:0] target);
      @(negedge clk);
      rob_set_pc_en = 1'b1;
      rob_set_pc    = target;
      @(negedge clk);
      rob_set_pc_en = 1'b0;
   endtask

   task automatic commit(input int n, input logic taken);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rob_br = 1'b1; rob_br_jump = taken; rob_br_pc = 32'h40;
      end
      @(negedge clk);
      rob_br = 1'b0;
   endtask

   task automatic run_sb(input string name);
      int n;
      issue_t e;
      n = 0;
      rob_nxt_full = 1'b0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
         if (inst_rdy) begin
            e = exp_q.pop_front();
            total++;
            if ({inst_pc, inst, inst_pred_jump} !== e) begin
               bad++;
               $display("FAIL %s: got pc=%h inst=%h jump=%b, expected pc=%h inst=%h jump=%b",
                        name, inst_pc, inst, inst_pred_jump, e.pc, e.inst, e.jump);
            end
         end
      end
      rob_nxt_full = 1'b1;
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL %s_timeout: %0d issues missing, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic settle();
      int quiet, n;
      quiet = 0; n = 0;
      while (quiet < 3 && n < 200) begin
         @(negedge clk);
         n++;
         quiet = mc_en ? 0 : quiet + 1;
      end
      if (quiet < 3) begin
         total++; bad++;
         $display("FAIL settle: mc_en=%b, expected 0", mc_en);
      end
      req_log.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({inst_rdy, inst_pred_jump, mc_en} !== 3'b000) begin
         bad++; $display("FAIL reset_flags: got rdy/jump/mc_en=%b, expected 000", {inst_rdy, inst_pred_jump, mc_en});
      end
      total++;
      if (inst !== 32'd0 || inst_pc !== 32'd0) begin
         bad++; $display("FAIL reset_inst: got inst=%h pc=%h, expected 0 0", inst, inst_pc);
      end
      total++;
      if (mc_addr !== 32'd0) begin
         bad++; $display("FAIL reset_mc_addr: got %h, expected 0", mc_addr);
      end
   endtask

   task automatic test_cold_start();
      int n;
      issue_t e;
      prog[32'h8] = JAL;
      push(32'h0, NOP, 1'b0); push(32'h4, NOP, 1'b0); push(32'h8, JAL, 1'b1); push(32'h18, NOP, 1'b0);
      rob_nxt_full = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (mc_en !== 1'b1 || mc_addr !== 32'h0) begin
         bad++; $display("FAIL cold_req: got mc_en=%b addr=%h, expected 1 00000000", mc_en, mc_addr);
      end
      n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (!mc_done && n < 50);
      @(negedge clk);
      total++;
      if (inst_rdy !== 1'b0) begin
         bad++; $display("FAIL cold_no_bypass: got inst_rdy=%b, expected 0", inst_rdy);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({inst_rdy, inst_pc, inst, inst_pred_jump} !== {1'b1, e}) begin
         bad++; $display("FAIL cold_first: got rdy=%b pc=%h inst=%h, expected rdy=1 pc=%h inst=%h",
                         inst_rdy, inst_pc, inst, e.pc, e.inst);
      end
      run_sb("cold_jal");
      total++;
`ifdef IFETCH_PREFETCH_EN
      if (req_log.size() < 2 || req_log[0] !== 32'h0 || req_log[1] !== 32'h40) begin
         bad++; $display("FAIL cold_prefetch: got %0d requests, expected 0x0 then 0x40", req_log.size());
      end
`else
      if (req_log.size() != 1 || req_log[0] !== 32'h0) begin
         bad++; $display("FAIL cold_reqs: got %0d requests, expected one at 0x0", req_log.size());
      end
`endif
   endtask

   task automatic test_bht();
      prog[32'h40] = BEQ;
      commit(3, 1'b1);
      push(32'h40, BEQ, 1'b1); push(32'h60, NOP, 1'b0);
      redirect(32'h40); run_sb("bht_taken");
      commit(2, 1'b0);
      push(32'h40, BEQ, 1'b0); push(32'h44, NOP, 1'b0);
      redirect(32'h40); run_sb("bht_not_taken");
      commit(2, 1'b0);
      commit(2, 1'b1);
      push(32'h40, BEQ, 1'b1); push(32'h60, NOP, 1'b0);
      redirect(32'h40); run_sb("bht_floor");
   endtask

   task automatic test_lru();
      prog[32'h400] = I400;
      prog[32'h800] = I800;
      settle();
      push(32'h400, I400, 1'b0); redirect(32'h400); run_sb("lru_fill_second");
      push(32'h0, NOP, 1'b0);    redirect(32'h0);   run_sb("lru_touch_first");
      push(32'h800, I800, 1'b0); redirect(32'h800); run_sb("lru_fill_third");
      settle();
      push(32'h0, NOP, 1'b0); redirect(32'h0); run_sb("lru_first_again");
      total++;
      if (req_log.size() != 0) begin
         bad++; $display("FAIL lru_keep_first: got %0d requests, expected 0", req_log.size());
      end
      settle();
      push(32'h400, I400, 1'b0); redirect(32'h400); run_sb("lru_second_again");
      total++;
      if (req_log.size() == 0 || req_log[0] !== 32'h400) begin
         bad++; $display("FAIL lru_evict_second: got %0d requests, expected first at 0x400", req_log.size());
      end
   endtask

   task automatic test_redirect_wait();
      int n;
      prog[32'h200] = I200;
      settle();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      req_log.delete();
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!mc_en && n < 20);
      push(32'h200, I200, 1'b0);
      redirect(32'h200);
      run_sb("redir_wait");
      total++;
`ifdef IFETCH_PREFETCH_EN
      if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h40 || req_log[2] !== 32'h200) begin
         bad++; $display("FAIL redir_reqs: got %0d requests, expected 0x0 0x40 0x200", req_log.size());
      end
`else
      if (req_log.size() != 2 || req_log[0] !== 32'h0 || req_log[1] !== 32'h200) begin
         bad++; $display("FAIL redir_reqs: got %0d requests, expected 0x0 then 0x200", req_log.size());
      end
`endif
      settle();
      push(32'h0, NOP, 1'b0); redirect(32'h0); run_sb("redir_fill_kept");
      total++;
      if (req_log.size() != 0) begin
         bad++; $display("FAIL redir_installed: got %0d requests, expected 0", req_log.size());
      end
   endtask

   task automatic test_stall();
      settle();
      push(32'h0, NOP, 1'b0); push(32'h4, NOP, 1'b0);
      redirect(32'h0); run_sb("stall_pre");
      @(negedge clk);
      total++;
      if (inst_rdy !== 1'b0) begin
         bad++; $display("FAIL stall_rob: got inst_rdy=%b, expected 0", inst_rdy);
      end
      rob_nxt_full = 1'b0; rs_nxt_full = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (inst_rdy !== 1'b0) begin
         bad++; $display("FAIL stall_rs: got inst_rdy=%b, expected 0", inst_rdy);
      end
      rs_nxt_full = 1'b0; lsb_nxt_full = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (inst_rdy !== 1'b0 || inst_pc !== 32'h4) begin
         bad++; $display("FAIL stall_lsb: got inst_rdy=%b pc=%h, expected 0 00000004", inst_rdy, inst_pc);
      end
      lsb_nxt_full = 1'b0; rob_nxt_full = 1'b1;
      push(32'h8, JAL, 1'b1); push(32'h18, NOP, 1'b0);
      run_sb("stall_resume");
   endtask

   task automatic test_rdy_freeze();
      issue_t e;
      push(32'h0, NOP, 1'b0); push(32'h4, NOP, 1'b0); push(32'h8, JAL, 1'b1);
      redirect(32'h0);
      rob_nxt_full = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({inst_rdy, inst_pc, inst, inst_pred_jump} !== {1'b1, e}) begin
         bad++; $display("FAIL freeze_first: got rdy=%b pc=%h, expected rdy=1 pc=%h", inst_rdy, inst_pc, e.pc);
      end
      rdy = 1'b0;
      rob_set_pc_en = 1'b1; rob_set_pc = 32'h300;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (inst_rdy !== 1'b1 || inst_pc !== 32'h0 || mc_en !== 1'b0) begin
            bad++; $display("FAIL freeze_hold: got rdy=%b pc=%h mc_en=%b, expected 1 00000000 0",
                            inst_rdy, inst_pc, mc_en);
         end
      end
      rob_set_pc_en = 1'b0;
      rdy = 1'b1;
      run_sb("freeze_resume");
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_bht();
      test_lru();
      test_redirect_wait();
      test_stall();
      test_rdy_freeze();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
